// File: rtl/dl_pkg.sv
// Shared definitions for the stream demultiplexer.
//   state_t : packet-tracking FSM state (IDLE = expecting a packet start,
//             LOCKED = mid-packet, destination held in lock_sel)
//   sel_w() : destination-select width for a given channel count
package dl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // At least one select bit, even for a two-channel demux.
    function automatic int sel_w(input int num_outs);
        return (num_outs > 2) ? $clog2(num_outs) : 1;
    endfunction

endpackage

// File: rtl/dl_pipe_reg.sv
// One-entry valid/ready register slice.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_data/i_valid      : upstream payload and valid
//   o_ready             : slice can take a beat this cycle
//   o_data/o_valid      : registered payload and valid
//   i_ready             : downstream accepts the held beat
// A new beat may load in the same cycle the held beat drains, so the
// slice sustains one beat per cycle.
module dl_pipe_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dl_demux_stream.sv
// Packet-aware stream demultiplexer.
// Routes each packet (beats up to and including in_last) to the channel
// named by in_sel on its first beat. Packets aimed at a non-existent
// channel are accepted and discarded, with err_sel pulsing once per beat.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_data/in_valid/in_last     : input beat
//   in_sel                       : destination, sampled on first beat only
//   in_ready                     : input handshake
//   out_data/out_last/out_valid  : per-channel outputs, channel c at
//                                  out_data[c*NUM_BITS +: NUM_BITS]
//   out_ready                    : per-channel downstream accept
//   err_sel                      : illegal-destination drop pulse
module dl_demux_stream
    import dl_pkg::*;
#(
    parameter int NUM_BITS = 32,
    parameter int NUM_OUTS = 2,
    localparam int SEL_W = sel_w(NUM_OUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BITS-1:0]          in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [SEL_W-1:0]             in_sel,
    output logic                         in_ready,
    output logic [NUM_OUTS*NUM_BITS-1:0] out_data,
    output logic [NUM_OUTS-1:0]          out_last,
    output logic [NUM_OUTS-1:0]          out_valid,
    input  logic [NUM_OUTS-1:0]          out_ready,
    output logic                         err_sel
);

    // Channel count widened by one bit so the select can be compared
    // against it even when NUM_OUTS is a power of two.
    localparam logic [SEL_W:0] NUM_OUTS_EXT = (SEL_W+1)'(NUM_OUTS);

    state_t           r_state;
    logic [SEL_W-1:0] r_lock_sel;
    logic             r_err_sel;

    logic [SEL_W-1:0]    w_active_sel;
    logic                w_sel_illegal;
    logic                w_dest_ready;
    logic                w_accept;
    logic [NUM_OUTS-1:0] w_ch_load;
    logic [NUM_OUTS-1:0] w_ch_ready;
    logic [NUM_BITS:0]   w_ch_payload [NUM_OUTS];

    assign w_active_sel  = (r_state == ST_LOCKED) ? r_lock_sel : in_sel;
    assign w_sel_illegal = ({1'b0, w_active_sel} >= NUM_OUTS_EXT);

    // Destination decode. An illegal select matches no channel, so ready
    // stays at its default of 1 and the beat is sunk.
    always_comb begin
        w_dest_ready = 1'b1;
        w_ch_load    = '0;
        for (int c = 0; c < NUM_OUTS; c++) begin
            if (w_active_sel == SEL_W'(c)) begin
                w_dest_ready = w_ch_ready[c];
                w_ch_load[c] = in_valid;
            end
        end
    end

    assign in_ready = w_dest_ready;
    assign w_accept = in_valid && w_dest_ready;
    assign err_sel  = r_err_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_sel <= '0;
            r_err_sel  <= 1'b0;
        end else begin
            r_err_sel <= w_accept && w_sel_illegal;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!in_last) begin
                            r_state    <= ST_LOCKED;
                            r_lock_sel <= in_sel;
                        end
                    end
                    ST_LOCKED: begin
                        if (in_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTS; gi++) begin : g_ch
            dl_pipe_reg #(
                .WIDTH (NUM_BITS + 1)
            ) u_pipe_reg (
                .clk     (clk),
                .rst     (rst),
                .i_data  ({in_last, in_data}),
                .i_valid (w_ch_load[gi]),
                .o_ready (w_ch_ready[gi]),
                .o_data  (w_ch_payload[gi]),
                .o_valid (out_valid[gi]),
                .i_ready (out_ready[gi])
            );
            assign out_data[gi*NUM_BITS +: NUM_BITS] = w_ch_payload[gi][NUM_BITS-1:0];
            assign out_last[gi]                      = w_ch_payload[gi][NUM_BITS];
        end
    endgenerate

endmodule

// File: tb/tb_dl_demux_stream.sv
module tb_dl_demux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 4 channels, 32-bit data
    logic         a_rst;
    logic [31:0]  a_in_data;
    logic         a_in_valid, a_in_last;
    logic [1:0]   a_in_sel;
    logic         a_in_ready;
    logic [127:0] a_out_data;
    logic [3:0]   a_out_last, a_out_valid, a_out_ready;
    logic         a_err;

    // Instance B: 3 channels (select value 3 is illegal), 16-bit data
    logic         b_rst;
    logic [15:0]  b_in_data;
    logic         b_in_valid, b_in_last;
    logic [1:0]   b_in_sel;
    logic         b_in_ready;
    logic [47:0]  b_out_data;
    logic [2:0]   b_out_last, b_out_valid, b_out_ready;
    logic         b_err;

    dl_demux_stream #(.NUM_BITS(32), .NUM_OUTS(4)) dut_a (
        .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_last(a_in_last), .in_sel(a_in_sel), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_last(a_out_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .err_sel(a_err)
    );

    dl_demux_stream #(.NUM_BITS(16), .NUM_OUTS(3)) dut_b (
        .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_sel(b_in_sel), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_last(b_out_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .err_sel(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic l);
        a_in_valid = v; a_in_sel = s; a_in_data = d; a_in_last = l;
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_out_ready = 4'hF; b_out_ready = 3'h7;
        a_drive(1'b1, 2'd1, 32'h1234_5678, 1'b1);
        b_in_valid = 1'b1; b_in_sel = 2'd0; b_in_data = 16'hAAAA; b_in_last = 1'b0;
        step(); step();
        checks++; if (a_out_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b want 0000", a_out_valid); end
        checks++; if (a_out_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_out_data); end
        checks++; if (a_out_last !== 4'h0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_last_err: last %b err %b want 0000/0", a_out_last, a_err); end
        checks++; if (b_out_valid !== 3'h0 || b_err !== 1'b0) begin errors++; $display("FAIL reset_b: valid %b err %b want 000/0", b_out_valid, b_err); end
        a_rst = 1'b0; b_rst = 1'b0;
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        b_in_valid = 1'b0;
        step();
        checks++; if (a_out_valid !== 4'h0) begin errors++; $display("FAIL reset_nostore: got %b want 0000", a_out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        a_out_ready = 4'hF;
        a_drive(1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", a_in_ready); end
        step();
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid: got %b want 0100", a_out_valid); end
        checks++; if (a_out_data[64 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", a_out_data[64 +: 32]); end
        checks++; if (a_out_last !== 4'b0100) begin errors++; $display("FAIL single_last: got %b want 0100", a_out_last); end
        step();
        checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain: got %b want 0000", a_out_valid); end
        $display("test_single_beat done");
    endtask

    task automatic test_lock();
        logic [31:0] d [3];
        logic [1:0]  s [3];
        d[0] = 32'h1111_0001; d[1] = 32'h2222_0002; d[2] = 32'h3333_0003;
        s[0] = 2'd1; s[1] = 2'd3; s[2] = 2'd3;
        a_out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, s[i], d[i], (i == 2));
            step();
            checks++; if (a_out_valid !== 4'b0010 || a_out_data[32 +: 32] !== d[i] || a_out_last[1] !== (i == 2))
                begin errors++; $display("FAIL lock_beat%0d: valid %b data %h last %b want 0010 %h %b",
                      i, a_out_valid, a_out_data[32 +: 32], a_out_last[1], d[i], (i == 2)); end
        end
        // Back in IDLE: a fresh single-beat packet to 3 must land on channel 3.
        a_drive(1'b1, 2'd3, 32'h4444_0004, 1'b1);
        step();
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        checks++; if (a_out_valid !== 4'b1000 || a_out_data[96 +: 32] !== 32'h4444_0004)
            begin errors++; $display("FAIL lock_release: valid %b data %h want 1000 44440004", a_out_valid, a_out_data[96 +: 32]); end
        step();
        $display("test_lock done");
    endtask

    task automatic test_backpressure();
        a_out_ready = 4'b1110;
        a_drive(1'b1, 2'd0, 32'hCAFE_0000, 1'b1);
        step();
        a_drive(1'b1, 2'd0, 32'hBAD0_BAD0, 1'b1);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0: got %b want 0", a_in_ready); end
        step();
        checks++; if (a_out_valid[0] !== 1'b1 || a_out_data[31:0] !== 32'hCAFE_0000)
            begin errors++; $display("FAIL bp_hold: valid %b data %h want 1 cafe0000", a_out_valid[0], a_out_data[31:0]); end
        a_drive(1'b1, 2'd1, 32'h0BEE_F001, 1'b1);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", a_in_ready); end
        step();
        checks++; if (a_out_valid !== 4'b0011 || a_out_data[32 +: 32] !== 32'h0BEE_F001 || a_out_data[31:0] !== 32'hCAFE_0000)
            begin errors++; $display("FAIL bp_other: valid %b d1 %h d0 %h want 0011 0beef001 cafe0000",
                  a_out_valid, a_out_data[32 +: 32], a_out_data[31:0]); end
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        a_out_ready = 4'hF;
        step();
        checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain: got %b want 0000", a_out_valid); end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        a_out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            a_drive(1'b1, 2'd0, d, 1'b1);
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, a_in_ready); end
            step();
            checks++; if (a_out_valid !== 4'b0001 || a_out_data[31:0] !== d)
                begin errors++; $display("FAIL b2b_beat%0d: valid %b data %h want 0001 %h", i, a_out_valid, a_out_data[31:0], d); end
        end
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_illegal_sel();
        b_out_ready = 3'h7;
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'h5A5A; b_in_last = 1'b0;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready0: got %b want 1", b_in_ready); end
        step();
        checks++; if (b_err !== 1'b1 || b_out_valid !== 3'b000) begin errors++; $display("FAIL ill_beat0: err %b valid %b want 1 000", b_err, b_out_valid); end
        // Locked to the illegal destination; the new select must be ignored.
        b_in_sel = 2'd0; b_in_data = 16'hA5A5; b_in_last = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready1: got %b want 1", b_in_ready); end
        step();
        checks++; if (b_err !== 1'b1 || b_out_valid !== 3'b000) begin errors++; $display("FAIL ill_beat1: err %b valid %b want 1 000", b_err, b_out_valid); end
        b_in_valid = 1'b0;
        step();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL ill_errclr: got %b want 0", b_err); end
        b_in_valid = 1'b1; b_in_sel = 2'd0; b_in_data = 16'h0C0C; b_in_last = 1'b1;
        step();
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 3'b001 || b_out_data[15:0] !== 16'h0C0C || b_err !== 1'b0)
            begin errors++; $display("FAIL ill_after: valid %b data %h err %b want 001 0c0c 0", b_out_valid, b_out_data[15:0], b_err); end
        step();
        $display("test_illegal_sel done");
    endtask

    task automatic test_reset_mid_packet();
        a_out_ready = 4'h0;
        a_drive(1'b1, 2'd0, 32'h0F0F_0F0F, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_valid: got %b want 0000", a_out_valid); end
        a_out_ready = 4'hF;
        a_drive(1'b1, 2'd1, 32'h7777_1111, 1'b1);
        step();
        a_drive(1'b0, 2'd0, 32'h0, 1'b0);
        checks++; if (a_out_valid !== 4'b0010 || a_out_data[32 +: 32] !== 32'h7777_1111)
            begin errors++; $display("FAIL rstmid_route: valid %b data %h want 0010 77771111", a_out_valid, a_out_data[32 +: 32]); end
        step();
        $display("test_reset_mid_packet done");
    endtask

    // Reference model: packet-level routing with a one-deep buffer per channel.
    task automatic test_random_soak();
        bit          m_locked;
        int          m_lock;
        bit          m_hv [3];
        logic [15:0] m_hd [3];
        bit          m_hl [3];
        bit          m_err;
        int          active;
        bit          exp_ready, acc;
        int          err_before;

        err_before = errors;
        b_rst = 1'b1; b_in_valid = 1'b0;
        step();
        b_rst = 1'b0;
        m_locked = 0; m_lock = 0; m_err = 0;
        for (int c = 0; c < 3; c++) begin m_hv[c] = 0; m_hd[c] = '0; m_hl[c] = 0; end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (b_out_valid[c] !== m_hv[c]) begin
                    errors++; $display("FAIL soak_valid cyc %0d ch %0d: got %b want %b", cyc, c, b_out_valid[c], m_hv[c]);
                end else if (m_hv[c]) begin
                    checks++;
                    if (b_out_data[c*16 +: 16] !== m_hd[c] || b_out_last[c] !== m_hl[c]) begin
                        errors++; $display("FAIL soak_data cyc %0d ch %0d: got %h/%b want %h/%b",
                                           cyc, c, b_out_data[c*16 +: 16], b_out_last[c], m_hd[c], m_hl[c]);
                    end
                end
            end
            checks++;
            if (b_err !== m_err) begin errors++; $display("FAIL soak_err cyc %0d: got %b want %b", cyc, b_err, m_err); end

            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_in_sel    = 2'($urandom_range(0, 3));
            b_in_data   = 16'($urandom);
            b_in_last   = ($urandom_range(0, 2) == 0);
            b_out_ready = 3'($urandom_range(0, 7));
            #1;
            active    = m_locked ? m_lock : int'(b_in_sel);
            exp_ready = (active >= 3) ? 1'b1 : (!m_hv[active] || b_out_ready[active]);
            checks++;
            if (b_in_ready !== exp_ready) begin errors++; $display("FAIL soak_ready cyc %0d: got %b want %b", cyc, b_in_ready, exp_ready); end

            acc = b_in_valid && exp_ready;
            for (int c = 0; c < 3; c++) begin
                if (acc && active == c) begin
                    m_hv[c] = 1; m_hd[c] = b_in_data; m_hl[c] = b_in_last;
                end else if (b_out_ready[c]) begin
                    m_hv[c] = 0;
                end
            end
            m_err = acc && (active >= 3);
            if (acc) begin
                if (!m_locked && !b_in_last) begin m_locked = 1; m_lock = int'(b_in_sel); end
                else if (m_locked && b_in_last) m_locked = 0;
            end
        end
        b_in_valid = 1'b0;
        step();
        $display("test_random_soak done: %0d new errors", errors - err_before);
    endtask

    initial begin
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_last = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_last = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
        test_reset();
        test_single_beat();
        test_lock();
        test_backpressure();
        test_back_to_back();
        test_illegal_sel();
        test_reset_mid_packet();
        test_random_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_demux_stream.md
DL_DEMUX_STREAM -- requirements
Module: dl_demux_stream

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, data width per beat.
REQ-002 SHALL have parameter NUM_OUTS, default 2, number of output channels (2..16); SEL_W = max(1, clog2(NUM_OUTS)).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_data  input  NUM_BITS  input beat payload.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_last  input  1  final beat of packet.
REQ-008 SHALL have port in_sel  input  SEL_W  destination channel, sampled on packet's first beat only.
REQ-009 SHALL have port in_ready  output  1  input beat accepted when in_valid and in_ready both high.
REQ-010 SHALL have port out_data  output  NUM_OUTS*NUM_BITS  channel c payload at bits [c*NUM_BITS +: NUM_BITS].
REQ-011 SHALL have port out_last  output  NUM_OUTS  per-channel last flag.
REQ-012 SHALL have port out_valid  output  NUM_OUTS  per-channel beat present.
REQ-013 SHALL have port out_ready  input  NUM_OUTS  per-channel downstream accept.
REQ-014 SHALL have port err_sel  output  1  one-cycle pulse when a beat is dropped for illegal destination.

Function
REQ-015 Each channel SHALL hold a one-entry register (valid, data, last); channel c can accept when !out_valid[c] or out_ready[c].
REQ-016 Active destination SHALL be in_sel in state IDLE and lock_sel in state LOCKED.
REQ-017 in_ready SHALL be combinational: can-accept of active destination; forced 1 if active destination >= NUM_OUTS.
REQ-018 Accepted beat SHALL appear on its channel's out_data/out_last with out_valid high on the next cycle (latency 1); no other channel is affected.
REQ-019 out_valid[c] SHALL clear after out_valid[c] and out_ready[c] unless a new beat loads channel c in the same cycle, in which case it stays high with the new data (full throughput, 1 beat/cycle per channel).
REQ-020 out_data/out_last SHALL hold stable while out_valid[c] high and out_ready[c] low.
REQ-021 FSM IDLE: accepted beat with in_last=0 -> LOCKED, lock_sel <= in_sel; accepted beat with in_last=1 -> stay IDLE (single-beat packet).
REQ-022 FSM LOCKED: in_sel ignored; accepted beat with in_last=1 -> IDLE; otherwise stay LOCKED.
REQ-023 No beat accepted (in_valid low or in_ready low) SHALL leave state and lock_sel unchanged.
REQ-024 Beat accepted while active destination >= NUM_OUTS SHALL be discarded, pulse err_sel next cycle, and follow REQ-021/022 transitions (whole packet sunk).
REQ-025 Stall on a busy channel SHALL NOT block drainage of other channels.

Reset
REQ-026 While rst high at a clock edge: state=IDLE, lock_sel=0, all out_valid=0, out_last=0, out_data=0, err_sel=0.
REQ-027 Reset mid-packet SHALL discard buffered beats and the lock; the first accepted beat after reset is treated as a packet start.
REQ-028 in_ready MAY be high during reset; beats presented during reset SHALL NOT be stored.

Structure
REQ-029 FSM state enum (IDLE, LOCKED) SHALL be a typedef in shared package dl_pkg.
REQ-030 Per-channel register slice SHALL be a sub-module dl_pipe_reg (NUM_BITS+1 payload, valid/ready), instantiated NUM_OUTS times via generate.
REQ-031 Top SHALL contain only FSM, lock_sel, destination decode, err_sel register.

Verification
REQ-032 Single-beat routing: NUM_OUTS=4, in_sel=2, in_data=0xDEADBEEF, in_last=1, all out_ready=1 -> next cycle out_valid=4'b0100, channel 2 data 0xDEADBEEF, out_last[2]=1.
REQ-033 Lock: 3-beat packet to sel=1 with in_sel toggled to 3 on beats 2-3 -> all 3 beats on channel 1, last only on beat 3, state IDLE after.
REQ-034 Backpressure: out_ready[0]=0 with channel 0 full -> in_ready=0 for sel=0, data held stable; beat to sel=1 still accepted same cycle.
REQ-035 Illegal sel: NUM_OUTS=3, in_sel=3, 2-beat packet -> in_ready=1 both beats, err_sel pulses twice, no out_valid asserted.
REQ-036 Reset mid-packet: rst high after beat 1 of 4 to sel=0 -> out_valid=0, state IDLE; next beat with in_sel=1 routes to channel 1.
REQ-037 Random soak: random in_valid/out_ready/in_sel, scoreboard per channel confirms order, no loss or duplication, packets never split across channels.
